// File: rtl/voice_reg_scheduler.sv
// Per-voice register bank with a frame sequencer that presents one voice per handshake.
// Writes aimed at the voice on the datapath wait in a two-entry pending FIFO.
module voice_reg_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 16
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic [5:0]        wr_addr_in,
    input  logic              wr_valid_in,
    input  logic              sample_tick_in,
    output logic              voice_valid_out,
    input  logic              voice_ready_in,
    output logic [1:0]        voice_idx_out,
    output logic [DATA_W-1:0] voice_freq_out,
    output logic [DATA_W-1:0] voice_vol_out,
    output logic [DATA_W-1:0] voice_ctrl_out,
    output logic              frame_done_out,
    output logic              overflow_out,
    output logic              tick_missed_out
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t            state;
    logic [DATA_W-1:0] bank_freq [4];
    logic [DATA_W-1:0] bank_vol  [4];
    logic [DATA_W-1:0] bank_ctrl [4];

    // Entry 0 is always the FIFO head; a drain shifts entry 1 down.
    logic [5:0]        fifo_addr [2];
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_cnt;

    logic              wr_mapped;
    logic              wr_conflict;
    logic              head_conflict;
    logic              fifo_full;
    logic              drain;
    logic              direct;
    logic              enq;
    logic              drop;
    logic              enq_slot;
    logic              commit_en;
    logic [5:0]        commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic              handshake;
    logic              last_voice;

    assign wr_mapped     = wr_valid_in && (wr_addr_in[3:0] <= 4'd2)
                           && ({1'b0, wr_addr_in[5:4]} < 3'(NUM_VOICES));
    assign wr_conflict   = (state == S_ISSUE) && (wr_addr_in[5:4] == voice_idx_out);
    assign head_conflict = (state == S_ISSUE) && (fifo_addr[0][5:4] == voice_idx_out);
    assign fifo_full     = (fifo_cnt == 2'(FIFO_DEPTH));
    assign drain         = (fifo_cnt != 2'd0) && !head_conflict;
    assign direct        = wr_mapped && (fifo_cnt == 2'd0) && !wr_conflict;
    assign enq           = wr_mapped && !direct && (!fifo_full || drain);
    assign drop          = wr_mapped && !direct && fifo_full && !drain;
    assign enq_slot      = 1'(fifo_cnt - {1'b0, drain});

    // Direct commits need an empty FIFO, so they can never collide with a drain.
    assign commit_en   = direct || drain;
    assign commit_addr = drain ? fifo_addr[0] : wr_addr_in;
    assign commit_data = drain ? fifo_data[0] : wr_data_in;

    assign handshake  = voice_valid_out && voice_ready_in;
    assign last_voice = (voice_idx_out == 2'(NUM_VOICES - 1));

    assign voice_freq_out = bank_freq[voice_idx_out];
    assign voice_vol_out  = bank_vol[voice_idx_out];
    assign voice_ctrl_out = bank_ctrl[voice_idx_out];

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state           <= S_IDLE;
            voice_valid_out <= 1'b0;
            voice_idx_out   <= 2'd0;
            frame_done_out  <= 1'b0;
            overflow_out    <= 1'b0;
            tick_missed_out <= 1'b0;
            fifo_cnt        <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                bank_freq[i] <= '0;
                bank_vol[i]  <= '0;
                bank_ctrl[i] <= '0;
            end
            for (int j = 0; j < 2; j++) begin
                fifo_addr[j] <= '0;
                fifo_data[j] <= '0;
            end
        end else begin
            frame_done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sample_tick_in) begin
                        state           <= S_ISSUE;
                        voice_valid_out <= 1'b1;
                        voice_idx_out   <= 2'd0;
                    end
                end
                S_ISSUE: begin
                    if (sample_tick_in) tick_missed_out <= 1'b1;
                    if (handshake) begin
                        if (last_voice) begin
                            state           <= S_IDLE;
                            voice_valid_out <= 1'b0;
                            voice_idx_out   <= 2'd0;
                            frame_done_out  <= 1'b1;
                        end else begin
                            voice_idx_out <= voice_idx_out + 2'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (commit_en) begin
                case (commit_addr[3:0])
                    4'd0:    bank_freq[commit_addr[5:4]] <= commit_data;
                    4'd1:    bank_vol[commit_addr[5:4]]  <= commit_data;
                    4'd2:    bank_ctrl[commit_addr[5:4]] <= commit_data;
                    default: ;
                endcase
            end

            if (drop) overflow_out <= 1'b1;

            // Shift first so a same-cycle enqueue into slot 0 wins.
            if (drain) begin
                fifo_addr[0] <= fifo_addr[1];
                fifo_data[0] <= fifo_data[1];
            end
            if (enq) begin
                fifo_addr[enq_slot] <= wr_addr_in;
                fifo_data[enq_slot] <= wr_data_in;
            end
            fifo_cnt <= fifo_cnt + 2'(enq) - 2'(drain);
        end
    end

endmodule

// File: tb/tb_voice_reg_scheduler.sv
// Scoreboard bench for voice_reg_scheduler: expected voice operands are queued at each
// tick and popped on every datapath handshake.
module tb_voice_reg_scheduler;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic [15:0] wr_data_in;
    logic [5:0]  wr_addr_in;
    logic        wr_valid_in;
    logic        sample_tick_in;
    logic        voice_valid_out;
    logic        voice_ready_in;
    logic [1:0]  voice_idx_out;
    logic [15:0] voice_freq_out;
    logic [15:0] voice_vol_out;
    logic [15:0] voice_ctrl_out;
    logic        frame_done_out;
    logic        overflow_out;
    logic        tick_missed_out;

    always #5 clk_in = ~clk_in;

    voice_reg_scheduler #(.NUM_VOICES(4), .FIFO_DEPTH(2), .DATA_W(16)) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .wr_data_in      (wr_data_in),
        .wr_addr_in      (wr_addr_in),
        .wr_valid_in     (wr_valid_in),
        .sample_tick_in  (sample_tick_in),
        .voice_valid_out (voice_valid_out),
        .voice_ready_in  (voice_ready_in),
        .voice_idx_out   (voice_idx_out),
        .voice_freq_out  (voice_freq_out),
        .voice_vol_out   (voice_vol_out),
        .voice_ctrl_out  (voice_ctrl_out),
        .frame_done_out  (frame_done_out),
        .overflow_out    (overflow_out),
        .tick_missed_out (tick_missed_out)
    );

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] f;
        logic [15:0] v;
        logic [15:0] c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mf [4];
    logic [15:0] mv [4];
    logic [15:0] mc [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drv_wr(input logic [5:0] a, input logic [15:0] d);
        wr_addr_in  = a;
        wr_data_in  = d;
        wr_valid_in = 1'b1;
        step();
        wr_valid_in = 1'b0;
    endtask

    task automatic wr_model(input logic [5:0] a, input logic [15:0] d);
        drv_wr(a, d);
        case (a[3:0])
            4'd0: mf[a[5:4]] = d;
            4'd1: mv[a[5:4]] = d;
            4'd2: mc[a[5:4]] = d;
            default: ;
        endcase
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mf[i] = 16'h0;
            mv[i] = 16'h0;
            mc[i] = 16'h0;
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.idx = 2'(i);
            e.f   = mf[i];
            e.v   = mv[i];
            e.c   = mc[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic tick_pulse();
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(voice_valid_out), 32'd0);
        chk({tag, "_idx"},   32'(voice_idx_out),   32'd0);
        chk({tag, "_freq"},  32'(voice_freq_out),  32'd0);
        chk({tag, "_vol"},   32'(voice_vol_out),   32'd0);
        chk({tag, "_ctrl"},  32'(voice_ctrl_out),  32'd0);
        chk({tag, "_fdone"}, 32'(frame_done_out),  32'd0);
        chk({tag, "_ovf"},   32'(overflow_out),    32'd0);
        chk({tag, "_tmiss"}, 32'(tick_missed_out), 32'd0);
    endtask

    // Handshake monitor: each accepted voice must match the next queued expectation.
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (reset_n_in === 1'b1 && voice_valid_out === 1'b1 && voice_ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_hs", 32'(voice_idx_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("hs_idx",  32'(voice_idx_out),  32'(e.idx));
                chk("hs_freq", 32'(voice_freq_out), 32'(e.f));
                chk("hs_vol",  32'(voice_vol_out),  32'(e.v));
                chk("hs_ctrl", 32'(voice_ctrl_out), 32'(e.c));
            end
        end
    end

    initial begin : main
        logic [15:0] old_f2;
        logic [15:0] old_f1;

        reset_n_in     = 1'b0;
        wr_data_in     = 16'h0;
        wr_addr_in     = 6'h0;
        wr_valid_in    = 1'b0;
        sample_tick_in = 1'b0;
        voice_ready_in = 1'b0;
        clear_model();
        step();
        step();
        reset_n_in = 1'b1;
        @(negedge clk_in);
        chk_all_zero("rst");
        step();

        // Basic writes and a full frame with ready tied high.
        wr_model(6'h00, 16'h1234);
        wr_model(6'h11, 16'h00FF);
        wr_model(6'h22, 16'h0A0A);
        wr_model(6'h31, 16'h7777);
        wr_model(6'h12, 16'h0C0C);
        voice_ready_in = 1'b1;
        push_frame();
        tick_pulse();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_in);
            chk("f1_valid", 32'(voice_valid_out), (c <= 4) ? 32'd1 : 32'd0);
            chk("f1_idx",   32'(voice_idx_out),   (c <= 4) ? 32'(c - 1) : 32'd0);
            chk("f1_fdone", 32'(frame_done_out),  (c == 5) ? 32'd1 : 32'd0);
        end
        step();

        // Unmapped register and unmapped addresses are dropped silently.
        drv_wr(6'h05, 16'hDEAD);
        drv_wr(6'h3F, 16'hBEEF);
        drv_wr(6'h03, 16'h5A5A);
        @(negedge clk_in);
        chk("unmap_ovf",   32'(overflow_out),    32'd0);
        chk("unmap_tmiss", 32'(tick_missed_out), 32'd0);
        step();
        push_frame();
        tick_pulse();
        repeat (6) step();

        // Hold voice 2; a write to it must stay deferred while presented.
        old_f2 = mf[2];
        push_frame();
        tick_pulse();
        step();
        step();
        voice_ready_in = 1'b0;
        drv_wr(6'h20, 16'hBEEF);
        repeat (3) begin
            @(negedge clk_in);
            chk("hold2_valid", 32'(voice_valid_out), 32'd1);
            chk("hold2_idx",   32'(voice_idx_out),   32'd2);
            chk("hold2_freq",  32'(voice_freq_out),  32'(old_f2));
        end
        step();
        voice_ready_in = 1'b1;
        repeat (5) step();
        mf[2] = 16'hBEEF;
        @(negedge clk_in);
        chk("hold2_ovf", 32'(overflow_out), 32'd0);
        step();
        push_frame();
        tick_pulse();
        repeat (6) step();

        // Hold voice 1; three writes fill the FIFO and the third is dropped.
        old_f1 = mf[1];
        push_frame();
        tick_pulse();
        step();
        voice_ready_in = 1'b0;
        drv_wr(6'h10, 16'h1111);
        drv_wr(6'h10, 16'h2222);
        drv_wr(6'h11, 16'h3333);
        @(negedge clk_in);
        chk("ovf_flag",  32'(overflow_out),    32'd1);
        chk("ovf_idx",   32'(voice_idx_out),   32'd1);
        chk("ovf_freq",  32'(voice_freq_out),  32'(old_f1));
        step();
        voice_ready_in = 1'b1;
        repeat (5) step();
        mf[1] = 16'h2222;
        push_frame();
        tick_pulse();
        repeat (6) step();
        @(negedge clk_in);
        chk("ovf_sticky", 32'(overflow_out), 32'd1);
        step();

        // Tick during a frame is missed; tick in the frame_done cycle starts a new frame.
        push_frame();
        push_frame();
        tick_pulse();
        tick_pulse();
        @(negedge clk_in);
        chk("tmiss_flag", 32'(tick_missed_out), 32'd1);
        step();
        step();
        step();
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        chk("tmiss_fdone", 32'(frame_done_out), 32'd1);
        step();
        sample_tick_in = 1'b0;
        @(negedge clk_in);
        chk("retick_valid", 32'(voice_valid_out), 32'd1);
        chk("retick_idx",   32'(voice_idx_out),   32'd0);
        step();
        repeat (6) step();

        // Reset in the middle of a frame clears everything.
        push_frame();
        tick_pulse();
        step();
        reset_n_in = 1'b0;
        step();
        reset_n_in = 1'b1;
        @(negedge clk_in);
        chk_all_zero("midrst");
        exp_q.delete();
        clear_model();
        step();
        push_frame();
        tick_pulse();
        repeat (6) step();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
